// File: rtl/bidir_piso_tx.sv
// Parallel-in serial-out transmitter with selectable bit order and a hold stall.
// Latency 1 from the handshake edge to the first bit. hold freezes the frame, and the next word is accepted only in IDLE.
module bidir_piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] par_in,
    input  logic             dir,
    input  logic             hold,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             dir_q;
    logic [CW-1:0]    cnt_q;
    logic             load_ready_q;
    logic             busy_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             done_q;
    logic             next_bit;

    // sreg_q always holds the presented bit at its output end, so the next bit sits one position inward.
    always_comb begin
        sreg_d   = dir_q ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
        next_bit = dir_q ? sreg_q[WIDTH-2] : sreg_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            dir_q        <= 1'b0;
            cnt_q        <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        state_q      <= SHIFT;
                        sreg_q       <= par_in;
                        dir_q        <= dir;
                        cnt_q        <= '0;
                        load_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        ser_out_q    <= dir ? par_in[WIDTH-1] : par_in[0];
                        ser_valid_q  <= 1'b1;
                        done_q       <= 1'b0;
                    end else begin
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                        ser_out_q    <= 1'b0;
                        ser_valid_q  <= 1'b0;
                        done_q       <= 1'b0;
                    end
                end
                SHIFT: begin
                    // done_q marks the cycle the last bit was presented, so the frame is complete.
                    if (done_q) begin
                        state_q      <= IDLE;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                        ser_out_q    <= 1'b0;
                        ser_valid_q  <= 1'b0;
                        done_q       <= 1'b0;
                    end else if (hold) begin
                        ser_valid_q  <= 1'b0;
                        done_q       <= 1'b0;
                    end else begin
                        sreg_q       <= sreg_d;
                        cnt_q        <= cnt_q + 1'b1;
                        ser_out_q    <= next_bit;
                        ser_valid_q  <= 1'b1;
                        done_q       <= (cnt_q == CNT_PENULT);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign done       = done_q;
endmodule

// File: doc/bidir_piso_tx.md
BIDIR_PISO_TX -- requirements
Module: bidir_piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: number of bits in the parallel word and the serial frame; WIDTH SHALL be at least 2.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port load_valid, input, 1 bit: par_in and dir are offered for transmission.
REQ-005 Port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-006 Port par_in, input, WIDTH bits: parallel word to serialise.
REQ-007 Port dir, input, 1 bit: bit order; 0 = LSB first (shift right), 1 = MSB first (shift left).
REQ-008 Port hold, input, 1 bit: stalls an in-progress frame.
REQ-009 Port ser_out, output, 1 bit: serial data bit, suitable for a serial-in shift register's data_in.
REQ-010 Port ser_valid, output, 1 bit: ser_out carries a valid frame bit this cycle.
REQ-011 Port busy, output, 1 bit: a frame is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse marking the last bit of a frame.

Function
REQ-013 The block SHALL implement two states, IDLE and SHIFT, and all outputs SHALL be registered.
REQ-014 In IDLE, outputs SHALL be load_ready=1, busy=0, ser_valid=0, ser_out=0 and done=0.
REQ-015 A handshake SHALL occur on a rising edge where load_valid=1 and load_ready=1; at that edge the block SHALL capture par_in into a WIDTH-bit shift register, latch dir, clear the bit counter and enter SHIFT.
REQ-016 In SHIFT, outputs SHALL be load_ready=0 and busy=1; load_valid, par_in and dir SHALL be ignored.
REQ-017 The first frame bit SHALL appear on ser_out with ser_valid=1 in the cycle immediately after the handshake edge (latency 1).
REQ-018 With latched dir=0, the bits SHALL be sent in order par_in[0] through par_in[WIDTH-1].
REQ-019 With latched dir=1, the bits SHALL be sent in order par_in[WIDTH-1] through par_in[0].
REQ-020 Each SHIFT cycle with hold=0 SHALL advance the shift register by one bit and increment the bit counter, which is ceil(log2(WIDTH)) bits wide.
REQ-021 In a SHIFT cycle with hold=1: shift register, counter and ser_out SHALL be frozen; ser_valid SHALL be 0; done SHALL be 0; busy SHALL stay 1.
REQ-022 Releasing hold SHALL resume the frame with the frozen bit, so that no bit is lost or duplicated in the stream of ser_valid=1 cycles.
REQ-023 done SHALL be 1 exactly in the cycle where the last (WIDTH-th) bit is presented with ser_valid=1, and SHALL be 0 otherwise.
REQ-024 If hold=1 while the last bit is pending, done SHALL be deferred until that bit is actually presented.
REQ-025 After the last bit, the block SHALL return to IDLE, with load_ready=1 in the following cycle.
REQ-026 A frame without hold SHALL therefore take WIDTH cycles, and back-to-back words SHALL have a period of WIDTH+1 cycles.
REQ-027 A load_valid held asserted across a frame SHALL be accepted again only at the next IDLE cycle.
REQ-028 An asserted load_valid SHALL be accepted only once per IDLE handshake edge.
REQ-029 hold asserted in IDLE SHALL have no effect and SHALL NOT block a handshake.

Reset
REQ-030 On a rising edge with reset=1, the block SHALL enter IDLE and clear the shift register, bit counter and latched dir to 0.
REQ-031 In the cycle after such an edge, outputs SHALL be load_ready=1, busy=0, ser_valid=0, ser_out=0 and done=0.
REQ-032 Reset SHALL take priority over a handshake, hold and shifting on the same edge.
REQ-033 Reset in mid-frame SHALL abort the frame with no done pulse.

Verification (WIDTH=4)
REQ-034 Scenario 1: reset=1 for 1 cycle then 0 -> load_ready=1, busy=0, ser_valid=0, ser_out=0, done=0.
REQ-035 Scenario 2: handshake with par_in=4'b1000, dir=0 -> ser_out=0,0,0,1 on 4 consecutive ser_valid cycles; done with the 4th bit; load_ready=1 in the next cycle.
REQ-036 Scenario 3: handshake with par_in=4'b1000, dir=1 -> ser_out=1,0,0,0; then par_in=4'b0110 with dir changed mid-frame -> second frame ignores that mid-frame change and sends 0,1,1,0 in its own latched order, with 5-cycle word spacing.
REQ-037 Scenario 4: par_in=4'b1011, dir=0, hold=1 for 2 cycles after bit 2 -> valid bit stream 1,1,0,1; ser_valid=0 and ser_out frozen during hold; done delayed by 2 cycles.
REQ-038 Scenario 5: reset=1 after bit 2 of a frame -> next cycle IDLE with all outputs at reset values and no done pulse; a new word 4'b0001, dir=1 then sends 0,0,0,1.
REQ-039 Scenario 6: load_valid=1 held continuously -> exactly one acceptance per IDLE cycle; par_in changes during SHIFT do not alter the bits sent.
